mem_req_arb_fifo: RTL and testbench
===================================

// Module: mem_req_arb_fifo
// PURPOSE
//  N-channel memory-request concentrator: arbitrates NUM_CH valid/ready request channels onto one
//  downstream memory request channel through a DEPTH-entry output FIFO. Sits between tile request
//  sources (MSHR/DMA engines) and the NoC encoder. Output is fully registered; requests gain a
//  source-channel tag. Arbitration mode is selectable: round-robin or fixed priority.
// PARAMETERS
//  NUM_CH    4  number of input request channels, 2..16
//  DEPTH     2  output FIFO entries, power of 2, >=2
//  ARB_MODE  0  0 = round-robin, 1 = fixed priority (ch0 highest)
//  SRC_W     $clog2(NUM_CH)  width of source tag (derived, not overridable)
// PORTS
//  clk        in   1              clock
//  rst        in   1              synchronous, active-high reset
//  in_valid   in   NUM_CH         per-channel request valid
//  in_ready   out  NUM_CH         per-channel request accepted
//  in_req     in   NUM_CH x mem_req_t  per-channel request payload
//  out_valid  out  1              downstream request valid
//  out_ready  in   1              downstream ready
//  out_req    out  mem_req_t      payload at FIFO head
//  out_src    out  SRC_W          channel index that issued out_req
//  fifo_cnt   out  $clog2(DEPTH)+1  current occupancy (debug/perf)
// BEHAVIOUR
//  Reset (rst=1 at posedge): FIFO emptied, rd/wr ptr=0, cnt=0, rr_ptr=0; out_valid=0, in_ready=0,
//   out_req/out_src=0, fifo_cnt=0. Reset mid-transfer drops all buffered requests; no partial state.
//  Handshake: transfer on valid&&ready at posedge, per channel and at output. Masters hold payload
//   and valid until accepted; block holds out_valid/out_req/out_src stable until out_ready.
//  Arbitration (combinational, 1 winner max): space = (cnt < DEPTH), registered state only -- no
//   out_ready->in_ready path. in_ready[i] = space && (i == winner) && in_valid[i]; others 0.
//   ARB_MODE=0: winner = first valid channel searching rr_ptr, rr_ptr+1, ... wrapping mod NUM_CH.
//   ARB_MODE=1: winner = lowest-index valid channel; rr_ptr unused.
//  rr_ptr update: only on input handshake; rr_ptr <= (winner+1) mod NUM_CH (wrap NUM_CH-1 -> 0).
//   No handshake (no valid or FIFO full) -> rr_ptr unchanged.
//  FIFO: push {in_req[winner], winner} on input handshake; pop on out_valid&&out_ready.
//   out_valid = (cnt != 0); out_req/out_src = entry at rd_ptr. Pointers wrap at DEPTH.
//   Simultaneous push+pop: cnt unchanged, both ptrs advance. Full: no push (in_ready all 0) even
//   if out_ready=1 that cycle. Empty: no pop; out_valid=0.
//  Latency: request accepted in cycle T appears on out_valid in T+1 (empty FIFO). Throughput
//   1 req/cycle when out_ready held high.
//  Width: mem_req_t fields unchanged; out_src zero-extended if NUM_CH not power of 2.
//   Indices >= NUM_CH never granted.
//  Assertions (non-synth): output hold-valid and payload-stable while stalled; at most one in_ready
//   bit set; cnt <= DEPTH; in_ready[i] implies in_valid[i].
// STRUCTURE
//  dcp_pkg: add mem_req_t packed struct {req_type_t, mshrid_t, paddr_t, size_t, homeid_t,
//   write_mask_t, data_t data_0, data_t data_1}; add ARB_RR/ARB_FIXED localparams.
//  Sub-module: mem_req_rr_arb (NUM_CH, ARB_MODE; in: req vector, rr_ptr; out: one-hot grant,
//   winner idx). FIFO storage and pointers inline in mem_req_arb_fifo.
// TESTING
//  1 rst held 3 cycles with all in_valid=1 -> in_ready=0, out_valid=0; release -> ch0 accepted first.
//  2 RR, all 4 valid, out_ready=1 -> accept order 0,1,2,3,0; out_src sequence same, 1 cycle later.
//  3 FIXED, ch1+ch3 valid continuously -> only ch1 granted; ch3 granted once ch1 drops valid.
//  4 out_ready=0, DEPTH=2: two reqs accepted, cnt=2, in_ready=0 third cycle; out_req stable;
//    raise out_ready -> addr order A0,A1 drained, cnt returns to 0.
//  5 full FIFO, out_ready=1 with ch2 valid -> pop occurs, no push that cycle; push next cycle.
//  6 rst asserted with cnt=2 mid-stall -> next cycle out_valid=0, cnt=0, rr_ptr=0.

Source files
------------

// File: rtl/mem_req_arb_fifo_pkg.sv
// mem_req_arb_fifo_pkg: memory request payload type and arbitration mode codes
package mem_req_arb_fifo_pkg;
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;
    typedef logic [2:0]  req_type_t;
    typedef logic [7:0]  mshrid_t;
    typedef logic [39:0] paddr_t;
    typedef logic [2:0]  size_t;
    typedef logic [7:0]  homeid_t;
    typedef logic [15:0] write_mask_t;
    typedef logic [63:0] data_t;
    typedef struct packed {
        req_type_t   req_type;
        mshrid_t     mshrid;
        paddr_t      addr;
        size_t       size;
        homeid_t     homeid;
        write_mask_t write_mask;
        data_t       data_0;
        data_t       data_1;
    } mem_req_t;
endpackage

// File: rtl/mem_req_arb_fifo_rr_arb.sv
// mem_req_rr_arb: single-winner arbiter, round-robin from rr_ptr_i or fixed priority with ch0 highest
module mem_req_rr_arb
    import mem_req_arb_fifo_pkg::*;
#(
    parameter int  NUM_CH   = 4,
    parameter int  ARB_MODE = ARB_RR,
    localparam int SRC_W    = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SRC_W-1:0]  rr_ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [SRC_W-1:0]  idx_o
);
    logic found;
    int   c;
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (ARB_MODE == ARB_FIXED) ? k : (int'(rr_ptr_i) + k) % NUM_CH;
            if (!found && req_i[c]) begin
                found    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = SRC_W'(c);
            end
        end
    end
endmodule

// File: rtl/mem_req_arb_fifo.sv
// mem_req_arb_fifo: arbitrates NUM_CH request channels into a DEPTH-entry output FIFO,
// tagging each buffered request with the channel that issued it
module mem_req_arb_fifo
    import mem_req_arb_fifo_pkg::*;
#(
    parameter int  NUM_CH   = 4,
    parameter int  DEPTH    = 2,
    parameter int  ARB_MODE = ARB_RR,
    localparam int SRC_W    = $clog2(NUM_CH),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     in_valid_i,
    output logic [NUM_CH-1:0]     in_ready_o,
    input  mem_req_t [NUM_CH-1:0] in_req_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output mem_req_t              out_req_o,
    output logic [SRC_W-1:0]      out_src_o,
    output logic [CNT_W-1:0]      fifo_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);

    mem_req_t          mem_q [DEPTH];
    logic [SRC_W-1:0]  src_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SRC_W-1:0]  rr_q, rr_d, win;
    logic [NUM_CH-1:0] gnt;
    logic              push, pop;

    mem_req_rr_arb #(.NUM_CH(NUM_CH), .ARB_MODE(ARB_MODE)) u_arb (
        .req_i    (in_valid_i),
        .rr_ptr_i (rr_q),
        .gnt_o    (gnt),
        .idx_o    (win)
    );

    // space uses registered occupancy only, so out_ready never feeds in_ready
    assign in_ready_o  = (!rst && cnt_q < CNT_W'(DEPTH)) ? gnt : '0;
    assign push        = |in_ready_o;
    assign out_valid_o = cnt_q != '0;
    assign pop         = out_valid_o && out_ready_i;
    assign out_req_o   = mem_q[rd_q];
    assign out_src_o   = src_q[rd_q];
    assign fifo_cnt_o  = cnt_q;
    assign cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
    assign rr_d        = (win == SRC_W'(NUM_CH - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            rr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                src_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_q] <= in_req_i[win];
                src_q[wr_q] <= win;
                wr_q        <= wr_q + 1'b1;
                rr_q        <= rr_d;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        out_valid_o && !out_ready_i |=> out_valid_o && $stable(out_req_o) && $stable(out_src_o));
    assert property (@(posedge clk) disable iff (rst)
        $onehot0(in_ready_o) && cnt_q <= CNT_W'(DEPTH) && (in_ready_o & ~in_valid_i) == '0);
endmodule

// File: tb/tb_mem_req_arb_fifo.sv
// tb_mem_req_arb_fifo: randomized scoreboard bench driving a round-robin and a fixed-priority instance
module tb_mem_req_arb_fifo;
    import mem_req_arb_fifo_pkg::*;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 2;
    localparam int SRC_W  = 2;
    localparam int CNT_W  = 2;
    typedef struct packed { mem_req_t req; logic [SRC_W-1:0] src; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_CH-1:0]     in_valid [2];
    logic [NUM_CH-1:0]     in_ready [2];
    mem_req_t [NUM_CH-1:0] in_req   [2];
    logic                  out_valid [2];
    logic                  out_ready [2];
    mem_req_t              out_req   [2];
    logic [SRC_W-1:0]      out_src   [2];
    logic [CNT_W-1:0]      fifo_cnt  [2];
    exp_t                  exp_q [2][$];

    int n_cmp = 0;
    int n_err = 0;
    logic [NUM_CH-1:0] mask = '1;
    int vprob = 100;
    int rdy_mode = 1;

    function automatic void chk(string nm, logic [255:0] act, logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endfunction

    function automatic mem_req_t rand_req();
        mem_req_t r;
        r.req_type   = 3'($urandom);
        r.mshrid     = 8'($urandom);
        r.addr       = {8'($urandom), $urandom};
        r.size       = 3'($urandom);
        r.homeid     = 8'($urandom);
        r.write_mask = 16'($urandom);
        r.data_0     = {$urandom, $urandom};
        r.data_1     = {$urandom, $urandom};
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_m
        int   rr = 0;
        int   acc = -1;
        int   c;
        logic rst_prev = 1'b1;
        exp_t e;

        mem_req_arb_fifo #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .ARB_MODE(g)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid_i  (in_valid[g]),
            .in_ready_o  (in_ready[g]),
            .in_req_i    (in_req[g]),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready[g]),
            .out_req_o   (out_req[g]),
            .out_src_o   (out_src[g]),
            .fifo_cnt_o  (fifo_cnt[g])
        );

        // reference model: predicts the grant from queue occupancy and the arbitration rule
        initial begin
            in_valid[g]  = '1;
            out_ready[g] = 1'b1;
            for (int i = 0; i < NUM_CH; i++) in_req[g][i] = rand_req();
            forever begin
                @(negedge clk);
                acc = -1;
                if (rst) begin
                    chk("rst_in_ready", 256'(in_ready[g]), 256'(0));
                    exp_q[g].delete();
                    rr = 0;
                end else begin
                    if (rst_prev) begin
                        chk("rst_out_valid", 256'(out_valid[g]), 256'(0));
                        chk("rst_out_req", 256'(out_req[g]), 256'(0));
                        chk("rst_out_src", 256'(out_src[g]), 256'(0));
                    end
                    chk("fifo_cnt", 256'(fifo_cnt[g]), 256'(exp_q[g].size()));
                    chk("out_valid", 256'(out_valid[g]), 256'(exp_q[g].size() != 0));
                    if (exp_q[g].size() < DEPTH)
                        for (int k = 0; k < NUM_CH; k++) begin
                            c = (g == 0) ? (rr + k) % NUM_CH : k;
                            if (acc < 0 && in_valid[g][c]) acc = c;
                        end
                    chk("in_ready", 256'(in_ready[g]), acc < 0 ? 256'(0) : 256'(1) << acc);
                    if (acc >= 0) begin
                        exp_q[g].push_back('{req: in_req[g][acc], src: SRC_W'(acc)});
                        rr = (acc + 1) % NUM_CH;
                    end
                end
                rst_prev = rst;
                @(posedge clk);
                #1;
                for (int i = 0; i < NUM_CH; i++)
                    if (i == acc || !in_valid[g][i]) begin
                        in_valid[g][i] = mask[i] && ($urandom_range(99) < vprob);
                        in_req[g][i]   = rand_req();
                    end
                out_ready[g] = (rdy_mode == 2) ? 1'($urandom_range(1)) : 1'(rdy_mode);
            end
        end

        initial forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid[g] && out_ready[g]) begin
                if (exp_q[g].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out[%0d]: got src %0d expected no output at %0t", g, out_src[g], $time);
                end else begin
                    e = exp_q[g].pop_front();
                    chk("out_req", 256'(out_req[g]), 256'(e.req));
                    chk("out_src", 256'(out_src[g]), 256'(e.src));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(12);
        mask = 4'b1010;
        step(10);
        mask = 4'b1000;
        step(6);
        mask = '1;
        rdy_mode = 0;
        step(6);
        rdy_mode = 1;
        step(6);
        rdy_mode = 0;
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        rdy_mode = 2;
        vprob = 50;
        step(3000);
        mask = '0;
        rdy_mode = 1;
        for (int k = 0; k < 100 && (exp_q[0].size() + exp_q[1].size()) != 0; k++) @(posedge clk);
        chk("drain_left", 256'(exp_q[0].size() + exp_q[1].size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
